// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared grid constants and food placer state encoding
package snake_pkg;

    localparam int GRID_BITS  = 3;
    localparam int GRID_CELLS = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADVANCE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_SCAN    = 2'd3
    } place_state_t;

endpackage

// File: rtl/food_placer.sv
// rtl/food_placer.sv - picks a free grid cell for food: random tries, then linear scan fallback
module food_placer
    import snake_pkg::*;
#(
    parameter int MAX_TRIES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spawn_req,
    output logic                 lfsr_en,
    input  logic [GRID_BITS-1:0] rand_x,
    input  logic [GRID_BITS-1:0] rand_y,
    output logic [GRID_BITS-1:0] query_x,
    output logic [GRID_BITS-1:0] query_y,
    input  logic                 occupied,
    output logic [GRID_BITS-1:0] food_x,
    output logic [GRID_BITS-1:0] food_y,
    output logic                 food_valid,
    output logic                 busy,
    output logic                 spawn_done,
    output logic                 grid_full
);

    localparam logic [7:0] TRIES_LIM = 8'(MAX_TRIES);
    // Scan covers every cell except the rejected random one.
    localparam logic [5:0] SCAN_LAST = 6'(GRID_CELLS - 2);

    place_state_t         r_state;
    logic [7:0]           r_tries;
    logic [5:0]           r_scan_cnt;
    logic [GRID_BITS-1:0] r_scan_x;
    logic [GRID_BITS-1:0] r_scan_y;
    logic [GRID_BITS-1:0] r_food_x;
    logic [GRID_BITS-1:0] r_food_y;
    logic                 r_food_valid;
    logic                 r_spawn_done;
    logic                 r_grid_full;

    logic [GRID_BITS-1:0] w_query_x;
    logic [GRID_BITS-1:0] w_query_y;
    logic [GRID_BITS-1:0] w_succ_x;
    logic [GRID_BITS-1:0] w_succ_y;
    logic [7:0]           w_tries_next;

    always_comb begin
        w_query_x = '0;
        w_query_y = '0;
        if (r_state == ST_CHECK) begin
            w_query_x = rand_x;
            w_query_y = rand_y;
        end else if (r_state == ST_SCAN) begin
            w_query_x = r_scan_x;
            w_query_y = r_scan_y;
        end
    end

    // Row-major successor; 3-bit wrap turns (7,7) into (0,0).
    assign w_succ_x     = w_query_x + GRID_BITS'(1);
    assign w_succ_y     = (w_query_x == {GRID_BITS{1'b1}}) ? w_query_y + GRID_BITS'(1) : w_query_y;
    assign w_tries_next = r_tries + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_tries      <= '0;
            r_scan_cnt   <= '0;
            r_scan_x     <= '0;
            r_scan_y     <= '0;
            r_food_x     <= '0;
            r_food_y     <= '0;
            r_food_valid <= 1'b0;
            r_spawn_done <= 1'b0;
            r_grid_full  <= 1'b0;
        end else begin
            r_spawn_done <= 1'b0;
            r_grid_full  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (spawn_req) begin
                        r_state      <= ST_ADVANCE;
                        r_food_valid <= 1'b0;
                        r_tries      <= '0;
                    end
                end
                ST_ADVANCE: r_state <= ST_CHECK;
                ST_CHECK: begin
                    r_tries <= w_tries_next;
                    if (!occupied) begin
                        r_food_x     <= w_query_x;
                        r_food_y     <= w_query_y;
                        r_food_valid <= 1'b1;
                        r_spawn_done <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else if (w_tries_next < TRIES_LIM) begin
                        r_state <= ST_ADVANCE;
                    end else begin
                        r_scan_x   <= w_succ_x;
                        r_scan_y   <= w_succ_y;
                        r_scan_cnt <= '0;
                        r_state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!occupied) begin
                        r_food_x     <= w_query_x;
                        r_food_y     <= w_query_y;
                        r_food_valid <= 1'b1;
                        r_spawn_done <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else if (r_scan_cnt == SCAN_LAST) begin
                        r_grid_full <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_scan_x   <= w_succ_x;
                        r_scan_y   <= w_succ_y;
                        r_scan_cnt <= r_scan_cnt + 6'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign lfsr_en    = (r_state == ST_ADVANCE);
    assign busy       = (r_state != ST_IDLE);
    assign query_x    = w_query_x;
    assign query_y    = w_query_y;
    assign food_x     = r_food_x;
    assign food_y     = r_food_y;
    assign food_valid = r_food_valid;
    assign spawn_done = r_spawn_done;
    assign grid_full  = r_grid_full;

endmodule
